// File: rtl/spi_slave_param.sv
// SPI mode-0 slave clocked directly by SCLK.
// Supports a configurable word width and bit order, and back-to-back words inside one CS frame.
// The TX side has one holding register with a valid/ready handshake.
// The RX side is a show-ahead FIFO.
// Overrun, underrun and frame-error flags are sticky until clear_flags.
module spi_slave_param #(
    parameter int                    DATA_WIDTH = 8,
    parameter bit                    LSB_FIRST  = 1'b1,
    parameter int                    RX_DEPTH   = 4,
    parameter logic [DATA_WIDTH-1:0] DEFAULT_TX = {DATA_WIDTH{1'b1}}
) (
    input  logic                            SCLK,
    input  logic                            reset,
    input  logic                            CS,
    input  logic                            MOSI,
    output logic                            MISO,
    input  logic [DATA_WIDTH-1:0]           tx_data,
    input  logic                            tx_valid,
    output logic                            tx_ready,
    output logic [DATA_WIDTH-1:0]           rx_data,
    output logic                            rx_valid,
    input  logic                            rx_read,
    output logic [$clog2(RX_DEPTH+1)-1:0]   rx_count,
    output logic                            overrun,
    output logic                            underrun,
    output logic                            frame_error,
    input  logic                            clear_flags,
    output logic                            busy
);

    localparam int             CW   = $clog2(DATA_WIDTH);
    localparam int             PW   = $clog2(RX_DEPTH);
    localparam int             NW   = $clog2(RX_DEPTH+1);
    localparam logic [CW-1:0]  LAST = CW'(DATA_WIDTH-1);

    typedef struct packed {
        logic overrun;
        logic underrun;
        logic frame_error;
    } flags_t;

    logic [CW-1:0]                          cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0]                  hold_q, hold_d;
    logic                                   hold_full_q, hold_full_d;
    logic [DATA_WIDTH-1:0]                  tx_cur_q, tx_cur_d;
    logic [DATA_WIDTH-1:0]                  rx_shift_q, rx_shift_d;
    logic [RX_DEPTH-1:0][DATA_WIDTH-1:0]    mem_q, mem_d;
    logic [PW-1:0]                          wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]                          rd_ptr_q, rd_ptr_d;
    logic [NW-1:0]                          count_q, count_d;
    flags_t                                 flags_q, flags_d;

    logic [CW-1:0]          idx;
    logic [DATA_WIDTH-1:0]  word_start;
    logic [DATA_WIDTH-1:0]  rx_word;
    logic                   push, pop, full, do_push;

    // Bit position for the current count, and the word a new SPI word would load.
    always_comb begin
        idx        = LSB_FIRST ? cnt_q : LAST - cnt_q;
        word_start = hold_full_q ? hold_q : DEFAULT_TX;
    end

    // MISO is combinational and only moves after a rising edge (count/holding change), giving mode-0 hold time.
    always_comb begin
        MISO = 1'b0;
        if (!CS) MISO = (cnt_q == '0) ? word_start[idx] : tx_cur_q[idx];
    end

    // Next-state: shift/count, TX load and handshake, RX FIFO push/pop, sticky flags.
    always_comb begin
        cnt_d       = cnt_q;
        hold_d      = hold_q;
        hold_full_d = hold_full_q;
        tx_cur_d    = tx_cur_q;
        rx_shift_d  = rx_shift_q;
        mem_d       = mem_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        flags_d     = flags_q;
        push        = 1'b0;

        rx_word      = rx_shift_q;
        rx_word[idx] = MOSI;

        // Clear first so that any set on the same edge wins.
        if (clear_flags) flags_d = '0;

        if (!CS) begin
            rx_shift_d = rx_word;
            if (cnt_q == '0) begin
                tx_cur_d = word_start;
                if (hold_full_q) hold_full_d = 1'b0;
                else             flags_d.underrun = 1'b1;
            end
            if (cnt_q == LAST) begin
                cnt_d = '0;
                push  = 1'b1;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end else begin
            // Partial word is abandoned.
            // The next word reloads tx_cur, so the consumed word is never re-sent.
            if (cnt_q != '0) flags_d.frame_error = 1'b1;
            cnt_d = '0;
        end

        // A write is accepted only when holding was empty at the start of the cycle.
        // A same-edge consume therefore takes DEFAULT_TX.
        if (tx_valid && !hold_full_q) begin
            hold_d      = tx_data;
            hold_full_d = 1'b1;
        end

        pop     = rx_read && (count_q != '0);
        full    = (count_q == NW'(RX_DEPTH));
        do_push = push && (!full || pop);
        if (push && full && !pop) flags_d.overrun = 1'b1;
        if (do_push) begin
            mem_d[wr_ptr_q] = rx_word;
            wr_ptr_d        = wr_ptr_q + 1'b1;
        end
        if (pop) rd_ptr_d = rd_ptr_q + 1'b1;
        count_d = count_q + NW'(do_push) - NW'(pop);
    end

    // State registers; reset drops any in-flight word without pushing it.
    always_ff @(posedge SCLK or negedge reset) begin
        if (!reset) begin
            cnt_q       <= '0;
            hold_q      <= '0;
            hold_full_q <= 1'b0;
            tx_cur_q    <= '0;
            rx_shift_q  <= '0;
            mem_q       <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            flags_q     <= '0;
        end else begin
            cnt_q       <= cnt_d;
            hold_q      <= hold_d;
            hold_full_q <= hold_full_d;
            tx_cur_q    <= tx_cur_d;
            rx_shift_q  <= rx_shift_d;
            mem_q       <= mem_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            flags_q     <= flags_d;
        end
    end

    assign tx_ready    = !hold_full_q;
    assign rx_valid    = (count_q != '0);
    assign rx_data     = rx_valid ? mem_q[rd_ptr_q] : '0;
    assign rx_count    = count_q;
    assign overrun     = flags_q.overrun;
    assign underrun    = flags_q.underrun;
    assign frame_error = flags_q.frame_error;
    assign busy        = (cnt_q != '0);

endmodule
